// File: rtl/fifo_ddr3_pkg.sv
// Shared definitions for the fifo-to-DDR3 bridge.
// Contents: bus widths, DDR user-port command codes, bridge FSM state codes
// and a helper that advances a DDR word address with 27-bit wrap.
package fifo_ddr3_pkg;

  localparam int ADDR_W = 27;   // DDR user-port address width
  localparam int DATA_W = 128;  // one DDR user-port word
  localparam int MASK_W = 16;   // one mask bit per data byte
  localparam int BURST_W = 6;   // upstream burst count field (beats - 1)
  localparam int BEAT_W = 7;    // holds 1..64 remaining beats

  // DDR user-port command encodings
  localparam logic [2:0] DDR_CMD_WR = 3'b000;
  localparam logic [2:0] DDR_CMD_RD = 3'b001;

  // Bridge FSM state codes
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RD   = 2'd3;

  // Upstream command type field
  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_type_e;

  // Next single-word DDR address; wraps naturally at 2^27.
  function automatic logic [ADDR_W-1:0] next_word_addr(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] step
  );
    return addr + step;
  endfunction

endpackage

// File: rtl/fifo_ddr3_bridge_if.sv
// Upstream fifo-style command/response bus of the DDR3 bridge.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The source holds valid and its payload stable until that
// edge; ready may depend combinationally on the sink's state, never on valid.
// Modports:
//   master : upstream (cache front-end) - drives command, takes responses
//   slave  : the bridge - accepts commands, returns read words in order
interface fifo_ddr3_bridge_if import fifo_ddr3_pkg::*; ();

  logic                fifo_cmd_valid;
  logic                fifo_cmd_ready;
  logic                fifo_cmd_type;       // 0 read, 1 write
  logic [ADDR_W-1:0]   fifo_cmd_addr;
  logic [BURST_W-1:0]  fifo_cmd_burst_cnt;  // read beats - 1
  logic [DATA_W-1:0]   fifo_cmd_wt_data;
  logic [MASK_W-1:0]   fifo_cmd_wt_mask;    // 1 = byte not written

  logic                fifo_rsp_valid;
  logic                fifo_rsp_ready;
  logic [DATA_W-1:0]   fifo_rsp_data;

  modport master (
    output fifo_cmd_valid, fifo_cmd_type, fifo_cmd_addr, fifo_cmd_burst_cnt,
           fifo_cmd_wt_data, fifo_cmd_wt_mask, fifo_rsp_ready,
    input  fifo_cmd_ready, fifo_rsp_valid, fifo_rsp_data
  );

  modport slave (
    input  fifo_cmd_valid, fifo_cmd_type, fifo_cmd_addr, fifo_cmd_burst_cnt,
           fifo_cmd_wt_data, fifo_cmd_wt_mask, fifo_rsp_ready,
    output fifo_cmd_ready, fifo_rsp_valid, fifo_rsp_data
  );

endinterface

// File: rtl/fifo_ddr3_rsp_fifo.sv
// First-word-fall-through synchronous FIFO holding returned read words.
// Ports:
//   clk, rstn        clock, async active-low reset
//   push, push_data  write one word (ignored when full)
//   pop              remove head word (ignored when empty)
//   empty            no word stored
//   count            words stored, 0..DEPTH
//   head_data        current head word, zero while empty
// A word pushed into an empty FIFO becomes visible on the next cycle.
module fifo_ddr3_rsp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && (count_q != CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_ddr3_bridge.sv
// fifo_ddr3_bridge: turns the cache front-end's fifo command/response stream
// into Gowin DDR3 user-port traffic. Reads are split into single-word DDR
// reads, each protected by a response-FIFO credit so returned data can never
// overflow; writes are single-word with byte masks. Read data returns in
// issue order. Single clock domain (DDR user clock).
// Ports:
//   clk, rstn            DDR user clock, async active-low reset
//   fifo                 upstream command/response bus (slave side)
//   ddr_*                Gowin DDR3 user port (command, write data, read data)
//   dbg_state            current FSM state code (ST_* in fifo_ddr3_pkg)
// Optional build macro FIFO_DDR3_BRIDGE_PERF_EN adds saturating counters:
//   perf_rd_words        read words issued to DDR
//   perf_wr_words        write words issued to DDR
//   perf_stall_cycles    cycles in RD/WR where the command was held back
module fifo_ddr3_bridge import fifo_ddr3_pkg::*; #(
  parameter int RSP_DEPTH = 16,
  parameter int ADDR_STEP = 8,
  parameter int INIT_WAIT = 1
) (
  input  logic               clk,
  input  logic               rstn,
  fifo_ddr3_bridge_if.slave  fifo,
  input  logic               ddr_init_done,
  input  logic               ddr_cmd_ready,
  output logic [2:0]         ddr_cmd,
  output logic               ddr_cmd_en,
  output logic [ADDR_W-1:0]  ddr_addr,
  input  logic               ddr_wr_data_rdy,
  output logic [DATA_W-1:0]  ddr_wr_data,
  output logic               ddr_wr_data_en,
  output logic               ddr_wr_data_end,
  output logic [MASK_W-1:0]  ddr_wr_data_mask,
  input  logic [DATA_W-1:0]  ddr_rd_data,
  input  logic               ddr_rd_data_valid,
  input  logic               ddr_rd_data_end,
  output logic [1:0]         dbg_state
`ifdef FIFO_DDR3_BRIDGE_PERF_EN
  ,
  output logic [31:0]        perf_rd_words,
  output logic [31:0]        perf_wr_words,
  output logic [31:0]        perf_stall_cycles
`endif
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam logic [15:0] INIT_WAIT_C = 16'(INIT_WAIT);

  logic [1:0]        state_q, state_d;
  logic [15:0]       init_cnt_q, init_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;

  logic              cmd_ready;
  logic              cmd_hs;
  logic              wr_fire;
  logic              rd_issue;
  logic              rd_push;
  logic              credit_ok;
  logic [CW:0]       in_use;
  logic              rsp_empty;
  logic [CW-1:0]     rsp_count;
  logic              unused_rd_end;

  // Single-word reads: the end strobe carries no extra information.
  assign unused_rd_end = ddr_rd_data_end;

  // Ready also drops the same cycle calibration is lost, so no command is
  // accepted that would immediately be abandoned.
  assign cmd_ready = (state_q == ST_IDLE) && ddr_init_done;
  assign cmd_hs    = fifo.fifo_cmd_valid && cmd_ready;

  // Every word in the FIFO or still in flight consumes one slot.
  assign in_use    = {1'b0, rsp_count} + {1'b0, outstanding_q};
  assign credit_ok = in_use < (CW+1)'(RSP_DEPTH);

  assign wr_fire  = (state_q == ST_WR) && ddr_init_done &&
                    ddr_cmd_ready && ddr_wr_data_rdy;
  assign rd_issue = (state_q == ST_RD) && ddr_init_done &&
                    ddr_cmd_ready && credit_ok;

  // Returns with nothing outstanding (e.g. after a reset) are discarded.
  assign rd_push = ddr_rd_data_valid && (outstanding_q != '0);

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    mask_d        = mask_q;
    beats_d       = beats_q;
    outstanding_d = outstanding_q + CW'(rd_issue) - CW'(rd_push);

    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q >= INIT_WAIT_C) state_d = ST_IDLE;
        else                           init_cnt_d = init_cnt_q + 16'd1;
      end
      ST_IDLE: begin
        if (cmd_hs) begin
          addr_d  = fifo.fifo_cmd_addr;
          data_d  = fifo.fifo_cmd_wt_data;
          mask_d  = fifo.fifo_cmd_wt_mask;
          beats_d = BEAT_W'(fifo.fifo_cmd_burst_cnt) + BEAT_W'(1);
          state_d = (fifo.fifo_cmd_type == CMD_WRITE) ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        if (wr_fire) state_d = ST_IDLE;
      end
      ST_RD: begin
        if (rd_issue) begin
          addr_d  = next_word_addr(addr_q, ADDR_W'(ADDR_STEP));
          beats_d = beats_q - BEAT_W'(1);
          if (beats_q == BEAT_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Losing calibration abandons whatever command is in progress and
    // restarts the settle count once it comes back.
    if (!ddr_init_done) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      mask_q        <= '0;
      beats_q       <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      beats_q       <= beats_d;
      outstanding_q <= outstanding_d;
    end
  end

  fifo_ddr3_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (rd_push),
    .push_data (ddr_rd_data),
    .pop       (fifo.fifo_rsp_ready),
    .empty     (rsp_empty),
    .count     (rsp_count),
    .head_data (fifo.fifo_rsp_data)
  );

  assign fifo.fifo_cmd_ready = cmd_ready;
  assign fifo.fifo_rsp_valid = !rsp_empty;

  // Command and write-data strobes come straight from the DDR readies so a
  // write is presented exactly once, in the cycle both sides accept it.
  assign ddr_cmd          = (state_q == ST_RD) ? DDR_CMD_RD : DDR_CMD_WR;
  assign ddr_cmd_en       = wr_fire || rd_issue;
  assign ddr_addr         = addr_q;
  assign ddr_wr_data      = data_q;
  assign ddr_wr_data_mask = mask_q;
  assign ddr_wr_data_en   = wr_fire;
  assign ddr_wr_data_end  = wr_fire;
  assign dbg_state        = state_q;

`ifdef FIFO_DDR3_BRIDGE_PERF_EN
  logic [31:0] perf_rd_q, perf_rd_d;
  logic [31:0] perf_wr_q, perf_wr_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall;

  assign stall = ((state_q == ST_RD) && !rd_issue) ||
                 ((state_q == ST_WR) && !wr_fire);

  always_comb begin
    perf_rd_d    = perf_rd_q;
    perf_wr_d    = perf_wr_q;
    perf_stall_d = perf_stall_q;
    if (rd_issue && (perf_rd_q != '1))    perf_rd_d    = perf_rd_q + 32'd1;
    if (wr_fire && (perf_wr_q != '1))     perf_wr_d    = perf_wr_q + 32'd1;
    if (stall && (perf_stall_q != '1))    perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_rd_q    <= perf_rd_d;
      perf_wr_q    <= perf_wr_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_rd_words     = perf_rd_q;
  assign perf_wr_words     = perf_wr_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: doc/fifo_ddr3_bridge.md
Name: fifo_ddr3_bridge

Overview:
Downstream stage of the AXI4 cache front-end: consumes its fifo-style command/response stream (128-bit words, 27-bit address) and drives the Gowin DDR3 memory-interface user port. Splits read bursts into single-word DDR accesses, issues single-word writes with byte masks, and returns read data in order through a credit-protected response FIFO. Runs entirely in the DDR user-clock domain.

Parameters:
RSP_DEPTH, 16, response FIFO depth in 128-bit words (power of two, >=2)
ADDR_STEP, 8, DDR address increment per 128-bit word (x16 device, BL8)
INIT_WAIT, 1, cycles after ddr_init_done rises before first command accepted

Ports:
clk  in  1  DDR user clock
rstn  in  1  async active-low reset
fifo_cmd_valid  in  1  command valid
fifo_cmd_ready  out  1  command accepted when valid&ready
fifo_cmd_type  in  1  0=read, 1=write
fifo_cmd_addr  in  27  start word address (DDR units)
fifo_cmd_burst_cnt  in  6  read beats minus one (1..64 words); ignored for writes
fifo_cmd_wt_data  in  128  write data
fifo_cmd_wt_mask  in  16  byte mask, 1=byte not written
fifo_rsp_valid  out  1  read word available
fifo_rsp_ready  in  1  upstream takes word
fifo_rsp_data  out  128  read word
ddr_init_done  in  1  calibration complete
ddr_cmd_ready  in  1  IP accepts command
ddr_cmd  out  3  3'b000 write, 3'b001 read
ddr_cmd_en  out  1  command strobe
ddr_addr  out  27  command address
ddr_wr_data_rdy  in  1  IP accepts write data
ddr_wr_data  out  128  write data
ddr_wr_data_en  out  1  write data strobe
ddr_wr_data_end  out  1  last write word (always = ddr_wr_data_en)
ddr_wr_data_mask  out  16  byte mask
ddr_rd_data  in  128  read data
ddr_rd_data_valid  in  1  read data strobe
ddr_rd_data_end  in  1  ignored (single-word reads)

Behaviour:
- Reset (rstn low, async): state=INIT, all outputs 0, ddr_cmd=3'b000, FIFO empty, outstanding=0. Reset mid-burst drops everything; in-flight DDR data after reset release is discarded while outstanding=0.
- States: INIT -> IDLE after ddr_init_done high for INIT_WAIT cycles. ddr_init_done falling in any state -> INIT (command in progress abandoned, fifo_cmd_ready=0).
- IDLE: fifo_cmd_ready=1. On handshake latch type/addr/cnt/data/mask; write -> WR, read -> RD (beats_left=burst_cnt+1). fifo_cmd_ready=0 in WR/RD.
- WR: assert ddr_cmd_en, ddr_wr_data_en, ddr_wr_data_end together only in a cycle where ddr_cmd_ready&ddr_wr_data_rdy; strobes are single-cycle, combinational on those readies from registered data. Then -> IDLE. Never assert cmd_en without wr_data_en.
- RD: issue one read per cycle when ddr_cmd_ready and credit>0; credit = RSP_DEPTH - fifo_count - outstanding. Each issue: addr += ADDR_STEP (27-bit wrap), outstanding++, beats_left--. beats_left reaching 0 -> IDLE (next command may start before reads return).
- ddr_rd_data_valid pushes ddr_rd_data into FIFO, outstanding--; simultaneous issue and return leave outstanding unchanged. Credit guarantees no overflow; valid with outstanding=0 is dropped.
- Response FIFO: first-word-fall-through; fifo_rsp_valid=!empty; simultaneous push/pop when full legal only via credit (cannot occur overfull). Pop and push same cycle on empty: data appears next cycle.
- Ordering: reads return in issue order; writes issued after earlier reads do not wait for read data.

Optional Feature:
FIFO_DDR3_BRIDGE_PERF_EN: adds outputs perf_rd_words[31:0], perf_wr_words[31:0], perf_stall_cycles[31:0] (cycles in RD/WR with command blocked by ready/credit); saturating, reset to 0. Without macro: ports and counters absent, behaviour otherwise identical.

Decomposition:
Package fifo_ddr3_pkg: DDR_CMD_WR/DDR_CMD_RD constants, state enum, data/mask/addr widths. One sub-module: fifo_ddr3_rsp_fifo (parameterised FWFT sync FIFO with count output).

Test Plan:
- Reset then ddr_init_done=1: fifo_cmd_ready rises after INIT_WAIT+1 cycles; drop init_done -> ready=0 next cycle.
- Write addr=0x100, data=0xA5.., mask=0x000F, wr_data_rdy low 3 cycles -> single cmd_en/wr_data_en/end pulse with cmd=000, addr=0x100, mask=0x000F after rdy rises.
- Read addr=0x40 burst_cnt=3 -> four reads at 0x40,0x48,0x50,0x58; returned words emerge in order on fifo_rsp.
- Read burst_cnt=63 with RSP_DEPTH=16, rsp_ready=0 -> exactly 16 reads issued then stall; releasing rsp_ready completes all 64 with no loss.
- Read addr=0x7FFFFF8 burst_cnt=1 -> second address wraps to 0x0000000.
- Assert rstn low during read burst with 5 outstanding -> outputs zero; late rd_data_valid pulses produce no fifo_rsp_valid.
